// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer and its helpers.
// Holds the control FSM states, the NOP control bundle and the timeout width helper.
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic wreg;
      logic m2reg;
      logic wmem;
   } ex_ctrl_t;

   localparam ex_ctrl_t NOP_CTRL = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0};

   function automatic int tmo_w(input int t);
      return (t <= 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use comparator between the ID-stage sources and the EX-stage load.
// Purely combinational; also instantiated by the forwarding unit.
module pipe_hazard_detect (
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   input  logic [4:0] ex_rn_i,
   input  logic       ex_wreg_i,
   input  logic       ex_m2reg_i,
   output logic       load_use_o
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_use_rs_i && (id_rs_i == ex_rn_i);
   assign rt_hit = id_use_rt_i && (id_rt_i == ex_rn_i);

   // r0 never carries a real dependency
   assign load_use_o = ex_m2reg_i && ex_wreg_i && (ex_rn_i != 5'd0)
                       && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer driving PC and pipeline-register enables.
// Optional memory timeout release is enabled by defining PIPE_MEM_TIMEOUT_EN.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [4:0]       ex_rn,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic             ex_br_taken,
   input  logic             m_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_err
);

   localparam int TW = tmo_w(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             load_use;
   logic             tmo;
   logic             go;

   pipe_hazard_detect u_detect (
      .id_rs_i     (id_rs),
      .id_rt_i     (id_rt),
      .id_use_rs_i (id_use_rs),
      .id_use_rt_i (id_use_rt),
      .ex_rn_i     (ex_rn),
      .ex_wreg_i   (ex_wreg),
      .ex_m2reg_i  (ex_m2reg),
      .load_use_o  (load_use)
   );

`ifdef PIPE_MEM_TIMEOUT_EN
   logic [TW-1:0] wait_q, wait_d;

   // Counter sits at zero in RUN, so MWAIT always starts from a clean count
   assign wait_d = (state_q == MWAIT) ? wait_q + 1'b1 : '0;
   assign tmo    = (state_q == MWAIT) && !dmem_ready
                   && (wait_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) wait_q <= '0;
      else         wait_q <= wait_d;
   end
`else
   assign tmo = 1'b0;
`endif

   assign go = (state_q == RUN) ? (!m_access || dmem_ready)
                                : (dmem_ready || tmo);

   always_comb begin
      dmem_req    = 1'b0;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      mem_err     = 1'b0;
      state_d     = state_q;
      if (resetn) begin
         if (go) begin
            dmem_req = m_access;
            mem_err  = tmo;
            state_d  = RUN;
            // A taken branch squashes the stalled instruction anyway
            if (ex_br_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
            end
         end else begin
            dmem_req = 1'b1;
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = MWAIT;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= RUN;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4).
// Build with PIPE_MEM_TIMEOUT_EN defined to cover the timeout release.
module tb_pipe_hazard_ctrl;

   logic       clock;
   logic       resetn;
   logic [4:0] id_rs, id_rt, ex_rn;
   logic       id_use_rs, id_use_rt;
   logic       ex_wreg, ex_m2reg, ex_br_taken;
   logic       m_access, dmem_ready;
   logic       dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       idex_bubble, ifid_flush, mem_err;
   logic [3:0] stall_cycles;

   int checks = 0;
   int failures = 0;

   // {dmem_req, pc, ifid, idex, exmem, memwb, bubble, flush}
   localparam logic [7:0] ALL   = 8'b0_11111_00;
   localparam logic [7:0] LU    = 8'b0_00111_10;
   localparam logic [7:0] BR    = 8'b0_11111_11;
   localparam logic [7:0] STALL = 8'b1_00000_00;
   localparam logic [7:0] REL   = 8'b1_11111_00;
   localparam logic [7:0] RELLU = 8'b1_00111_10;

   pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .ex_rn        (ex_rn),
      .ex_wreg      (ex_wreg),
      .ex_m2reg     (ex_m2reg),
      .ex_br_taken  (ex_br_taken),
      .m_access     (m_access),
      .dmem_ready   (dmem_ready),
      .dmem_req     (dmem_req),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .idex_bubble  (idex_bubble),
      .ifid_flush   (ifid_flush),
      .stall_cycles (stall_cycles),
      .mem_err      (mem_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [7:0] e_ctl,
                      input int e_st, input logic e_err);
      logic [7:0] ctl;
      logic [3:0] st;
      ctl = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             idex_bubble, ifid_flush};
      st  = 4'(e_st);
      checks++;
      assert (ctl === e_ctl) else begin
         failures++;
         $error("FAIL %s ctl got=%b exp=%b", tag, ctl, e_ctl);
      end
      checks++;
      assert (stall_cycles === st) else begin
         failures++;
         $error("FAIL %s stall_cycles got=%0d exp=%0d", tag, stall_cycles, st);
      end
      checks++;
      assert (mem_err === e_err) else begin
         failures++;
         $error("FAIL %s mem_err got=%b exp=%b", tag, mem_err, e_err);
      end
   endtask

   task automatic set_lu(input logic on);
      ex_m2reg  = on;
      ex_wreg   = on;
      ex_rn     = 5'd5;
      id_rs     = 5'd5;
      id_use_rs = 1'b1;
      id_rt     = 5'd1;
      id_use_rt = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      id_rs = '0; id_rt = '0; ex_rn = '0;
      id_use_rs = 0; id_use_rt = 0;
      ex_wreg = 0; ex_m2reg = 0; ex_br_taken = 0;
      m_access = 1'b1; dmem_ready = 1'b0;

      @(negedge clock); #1 chk("reset", ALL, 0, 0);

      @(negedge clock); resetn = 1'b1; m_access = 1'b0; set_lu(1);
      #1 chk("load_use", LU, 0, 0);
      @(negedge clock); set_lu(0);
      #1 chk("lu_after", ALL, 1, 0);

      @(negedge clock);
      ex_m2reg = 1; ex_wreg = 1; ex_rn = 0; id_rs = 0; id_use_rs = 1;
      #1 chk("rn_zero", ALL, 1, 0);
      @(negedge clock);
      ex_rn = 5; id_rs = 5; id_use_rs = 0; id_rt = 1; id_use_rt = 1;
      #1 chk("rs_unused", ALL, 1, 0);
      @(negedge clock); id_rt = 5;
      #1 chk("rt_match", LU, 1, 0);
      @(negedge clock); ex_wreg = 0;
      #1 chk("no_wreg", ALL, 2, 0);

      @(negedge clock); set_lu(1); ex_br_taken = 1;
      #1 chk("br_over_lu", BR, 2, 0);

      @(negedge clock); set_lu(0); ex_br_taken = 0;
      m_access = 1; dmem_ready = 0;
      #1 chk("mem_stall1", STALL, 2, 0);
      @(negedge clock); set_lu(1); ex_br_taken = 1;
      #1 chk("mem_stall2", STALL, 3, 0);
      @(negedge clock); set_lu(0); ex_br_taken = 0;
      #1 chk("mem_stall3", STALL, 4, 0);
      @(negedge clock); dmem_ready = 1; set_lu(1);
      #1 chk("mem_release", RELLU, 5, 0);
      @(negedge clock); set_lu(0); m_access = 0; dmem_ready = 0;
      #1 chk("after_rel", ALL, 6, 0);

      @(negedge clock); m_access = 1;
      #1 chk("mw_a", STALL, 6, 0);
      @(negedge clock);
      #1 chk("mw_b", STALL, 7, 0);
      @(negedge clock); resetn = 0;
      #1 chk("rst_in_mwait", ALL, 0, 0);
      @(negedge clock); resetn = 1; m_access = 0; set_lu(1);
      #1 chk("run_after_rst", LU, 0, 0);

      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         #1 chk("saturate", LU, (k >= 15) ? 15 : k, 0);
      end

      @(negedge clock); set_lu(0); resetn = 0;
      @(negedge clock); resetn = 1; m_access = 1; dmem_ready = 0;
      #1 chk("wait_run", STALL, 0, 0);
`ifdef PIPE_MEM_TIMEOUT_EN
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         #1 chk("tmo_wait", STALL, k, 0);
      end
      @(negedge clock);
      #1 chk("tmo_release", REL, 8, 1);
      @(negedge clock); m_access = 0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("tmo_after", ALL, 8, 0);
         @(negedge clock);
      end
`else
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         #1 chk("no_tmo_wait", STALL, k, 0);
      end
      @(negedge clock); dmem_ready = 1;
      #1 chk("late_release", REL, 13, 0);
      @(negedge clock); m_access = 0; dmem_ready = 0;
      #1 chk("late_after", ALL, 13, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
